sort_job_arbiter: RTL and testbench

- Round-robin scheduler that shares one 64-bit (8 x 8-bit) bitonic sort pipeline among NREQ requesters.
- Accepts a job from one requester at a time and issues it to the sorter with a one-cycle valid pulse.
- Waits for the sorter's completion or a timeout, then returns the sorted vector tagged with the requester index.
- Sits between the host-side request ports and the sorter core; the sorter handles one job at a time.

---
 rtl/sort_job_arbiter.sv | 175 +++++++++++++++++
 tb/tb_sort_job_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_job_arbiter.sv
// Round-robin front end sharing one 8x8-bit sort pipeline among NREQ requesters.
// Optional SORT_ORDER_CHECK_EN adds order_err, flagging results that are not correctly ordered.
module sort_job_arbiter #(
    parameter int NREQ      = 4,
    parameter int IDW       = 3,
    parameter int TIMEOUT   = 16,
    parameter int ASCENDING = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*64-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic [63:0]          sort_in,
    output logic                 sort_valid_in,
    input  logic [63:0]          sort_out,
    input  logic                 sort_valid_out,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [IDW-1:0]       resp_id,
    output logic [63:0]          resp_data,
    output logic                 timeout_err,
    output logic [15:0]          done_cnt
`ifdef SORT_ORDER_CHECK_EN
    ,
    output logic                 order_err
`endif
);

    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DELIVER} state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  last_grant_q, last_grant_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [63:0]     job_q, job_d;
    logic [63:0]     data_q, data_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [15:0]     done_cnt_q, done_cnt_d;
    logic [IDW-1:0]  grant, g_lo, g_hi;
    logic            any_req, any_hi;
    logic            complete, expired;

    // True when adjacent bytes (byte 0 at the MSB end) break the configured order; ties allowed.
    function automatic logic order_bad(input logic [63:0] v);
        logic       bad;
        logic [7:0] a, b;
        bad = 1'b0;
        for (int k = 0; k < 7; k++) begin
            a = v[63-8*k -: 8];
            b = v[55-8*k -: 8];
            if ((ASCENDING != 0) ? (a > b) : (a < b)) bad = 1'b1;
        end
        return bad;
    endfunction

    // Lowest set bit above last_grant wins; otherwise wrap to the lowest set bit overall.
    always_comb begin
        any_req = 1'b0;
        any_hi  = 1'b0;
        g_lo    = '0;
        g_hi    = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                any_req = 1'b1;
                g_lo    = IDW'(i);
                if (i > int'(last_grant_q)) begin
                    any_hi = 1'b1;
                    g_hi   = IDW'(i);
                end
            end
        end
        grant = any_hi ? g_hi : g_lo;
    end

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        id_d          = id_q;
        job_d         = job_q;
        data_d        = data_q;
        timer_d       = timer_q;
        done_cnt_d    = done_cnt_q;
        req_ready     = '0;
        sort_valid_in = 1'b0;
        sort_in       = '0;
        resp_valid    = 1'b0;
        resp_id       = '0;
        resp_data     = '0;
        timeout_err   = 1'b0;
        // The first WAIT cycle (timer 0) may still see the previous job's completion level.
        complete      = sort_valid_out && (timer_q != '0);
        expired       = (timer_q == TW'(TIMEOUT - 1));

        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    for (int i = 0; i < NREQ; i++) begin
                        if (grant == IDW'(i)) begin
                            req_ready[i] = 1'b1;
                            job_d        = req_data[i*64 +: 64];
                        end
                    end
                    id_d         = grant;
                    last_grant_d = grant;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                sort_valid_in = 1'b1;
                sort_in       = job_q;
                timer_d       = '0;
                state_d       = S_WAIT;
            end
            S_WAIT: begin
                timer_d = timer_q + 1'b1;
                if (complete) begin
                    data_d  = sort_out;
                    state_d = S_DELIVER;
                end else if (expired) begin
                    timeout_err = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            S_DELIVER: begin
                resp_valid = 1'b1;
                resp_id    = id_q;
                resp_data  = data_q;
                if (resp_ready) begin
                    done_cnt_d = done_cnt_q + 16'd1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= IDW'(NREQ - 1);
            timer_q      <= '0;
            done_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            timer_q      <= timer_d;
            done_cnt_q   <= done_cnt_d;
        end
        id_q   <= id_d;
        job_q  <= job_d;
        data_q <= data_d;
    end

    assign done_cnt = done_cnt_q;

`ifdef SORT_ORDER_CHECK_EN
    logic order_err_q, order_err_d;

    // Registered at capture so the flag lines up with the first resp_valid cycle.
    always_comb begin
        order_err_d = 1'b0;
        if (state_q == S_WAIT && complete) order_err_d = order_bad(sort_out);
    end

    always_ff @(posedge clk) begin
        if (!rst) order_err_q <= 1'b0;
        else      order_err_q <= order_err_d;
    end

    assign order_err = order_err_q;
`endif

endmodule

// File: tb/tb_sort_job_arbiter.sv
// Scoreboard bench for sort_job_arbiter with a behavioural sorter (latency 8) and round-robin model.
// Define SORT_ORDER_CHECK_EN to also exercise order_err.
module tb_sort_job_arbiter;

    localparam int NREQ    = 4;
    localparam int IDW     = 3;
    localparam int TIMEOUT = 16;
    localparam int LAT     = 8;

    localparam int K_NORMAL = 0;
    localparam int K_MUTE   = 1;
    localparam int K_STALL  = 2;
    localparam int K_RESET  = 3;
    localparam int K_BAD    = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ*64-1:0]  req_data = '0;
    logic [NREQ-1:0]     req_ready;
    logic [63:0]         sort_in;
    logic                sort_valid_in;
    logic [63:0]         sv_data;
    logic                sv_out;
    logic                resp_valid;
    logic                resp_ready = 1'b0;
    logic [IDW-1:0]      resp_id;
    logic [63:0]         resp_data;
    logic                timeout_err;
    logic [15:0]         done_cnt;
`ifdef SORT_ORDER_CHECK_EN
    logic                order_err;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic           bad;
        logic [IDW-1:0] id;
        logic [63:0]    data;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] issue_q[$];

    bit  mon_en = 0;
    bit  rr_rand = 0;
    bit  rr_force = 1;
    bit  sorter_mute = 0;
    bit  sorter_bad = 0;
    int  model_last = NREQ - 1;

    always #5 clk = ~clk;

    sort_job_arbiter #(
        .NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT), .ASCENDING(1)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .sort_in(sort_in), .sort_valid_in(sort_valid_in),
        .sort_out(sv_data), .sort_valid_out(sv_out),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_data(resp_data),
        .timeout_err(timeout_err), .done_cnt(done_cnt)
`ifdef SORT_ORDER_CHECK_EN
        ,
        .order_err(order_err)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] sort_bytes(input logic [63:0] v);
        logic [7:0]  b[8];
        logic [7:0]  t;
        logic [63:0] r;
        for (int i = 0; i < 8; i++) b[i] = v[63-8*i -: 8];
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 7 - i; j++)
                if (b[j] > b[j+1]) begin
                    t = b[j]; b[j] = b[j+1]; b[j+1] = t;
                end
        for (int i = 0; i < 8; i++) r[63-8*i -: 8] = b[i];
        return r;
    endfunction

    function automatic int pick(input logic [NREQ-1:0] m, input int last);
        for (int k = 1; k <= NREQ; k++)
            if (m[(last + k) % NREQ]) return (last + k) % NREQ;
        return 0;
    endfunction

    // Sorter model: result level rises LAT cycles after the issue edge; the old level lingers one cycle.
    int          s_cnt;
    bit          s_pend, s_clear;
    logic [63:0] s_buf;
    always @(posedge clk) begin
        if (!rst) begin
            sv_out  <= 1'b0;
            sv_data <= '0;
            s_pend  <= 1'b0;
            s_clear <= 1'b0;
            s_cnt   <= 0;
        end else begin
            s_clear <= 1'b0;
            if (s_clear) sv_out <= 1'b0;
            if (sort_valid_in) begin
                s_clear <= 1'b1;
                s_pend  <= !sorter_mute;
                s_cnt   <= 1;
                s_buf   <= sorter_bad ? 64'h0201030405060708 : sort_bytes(sort_in);
            end else if (s_pend) begin
                if (s_cnt == LAT) begin
                    sv_out  <= 1'b1;
                    sv_data <= s_buf;
                    s_pend  <= 1'b0;
                end else begin
                    s_cnt <= s_cnt + 1;
                end
            end
        end
    end

    always @(posedge clk) begin
        #2;
        resp_ready = rr_rand ? ($urandom_range(0, 2) != 0) : rr_force;
    end

    // Monitor: pops the scoreboard whenever the DUT presents an issue or a response.
    bit             prev_rst = 0, prev_hs = 0, prev_rv = 0;
    logic [IDW-1:0] prev_id = '0;
    logic [63:0]    prev_data = '0;
    logic [15:0]    model_done = '0;
    exp_t           e_front;
    logic [63:0]    i_front;
    always @(negedge clk) begin
        if (!prev_rst) begin
            model_done = '0;
            exp_q.delete();
        end else if (prev_hs) begin
            model_done = model_done + 16'd1;
        end
        if (mon_en) begin
            check("done_cnt", 64'(done_cnt), 64'(model_done));
            if (!resp_valid) begin
                check("idle_resp_id", 64'(resp_id), 64'd0);
                check("idle_resp_data", resp_data, 64'd0);
            end else if (prev_rv) begin
                check("hold_resp_id", 64'(resp_id), 64'(prev_id));
                check("hold_resp_data", resp_data, prev_data);
            end
            if (sort_valid_in) begin
                if (issue_q.size() == 0) begin
                    check("sort_valid_in_unexpected", 64'(sort_valid_in), 64'd0);
                end else begin
                    i_front = issue_q.pop_front();
                    check("sort_in", sort_in, i_front);
                end
            end
`ifdef SORT_ORDER_CHECK_EN
            if (resp_valid && !prev_rv && exp_q.size() != 0)
                check("order_err_first", 64'(order_err), 64'(exp_q[0].bad));
            else
                check("order_err_quiet", 64'(order_err), 64'd0);
`endif
            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    check("resp_unexpected", 64'(resp_valid), 64'd0);
                end else begin
                    e_front = exp_q.pop_front();
                    check("resp_id", 64'(resp_id), 64'(e_front.id));
                    check("resp_data", resp_data, e_front.data);
                end
            end
        end
        prev_rst  = rst;
        prev_hs   = resp_valid && resp_ready;
        prev_rv   = resp_valid;
        prev_id   = resp_id;
        prev_data = resp_data;
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        check({tag, "_sort_valid_in"}, 64'(sort_valid_in), 64'd0);
        check({tag, "_sort_in"}, sort_in, 64'd0);
        check({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
        check({tag, "_resp_id"}, 64'(resp_id), 64'd0);
        check({tag, "_resp_data"}, resp_data, 64'd0);
        check({tag, "_timeout_err"}, 64'(timeout_err), 64'd0);
        check({tag, "_done_cnt"}, 64'(done_cnt), 64'd0);
    endtask

    task automatic wait_drained();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("resp_drained", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
    endtask

    task automatic do_job(input logic [NREQ-1:0] mask, input int kind,
                          input bit fixed, input logic [63:0] d0);
        int              g, n, tcnt, tpos, rvc, svc;
        bit              got;
        logic [NREQ-1:0] oh;
        logic [63:0]     gd;
        exp_t            e;
        @(posedge clk); #1;
        sorter_mute = (kind == K_MUTE);
        sorter_bad  = (kind == K_BAD);
        for (int i = 0; i < NREQ; i++) req_data[i*64 +: 64] = {$urandom, $urandom};
        if (fixed) req_data[63:0] = d0;
        req_valid = mask;
        g  = pick(mask, model_last);
        oh = '0;
        oh[g] = 1'b1;
        got = 0;
        n = 0;
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            if (req_ready != '0) got = 1;
        end
        check("grant_seen", 64'(got), 64'd1);
        if (!got) begin
            req_valid = '0;
            return;
        end
        check("req_ready_onehot", 64'(req_ready), 64'(oh));
        gd = req_data[g*64 +: 64];
        @(posedge clk); #1;
        req_valid  = '0;
        model_last = g;
        issue_q.push_back(gd);
        e.id   = IDW'(g);
        e.bad  = (kind == K_BAD);
        e.data = (kind == K_BAD) ? 64'h0201030405060708 : sort_bytes(gd);
        if (kind == K_NORMAL || kind == K_BAD || kind == K_STALL) exp_q.push_back(e);

        if (kind == K_MUTE) begin
            tcnt = 0; tpos = 0; rvc = 0;
            for (n = 1; n <= 24; n++) begin
                @(negedge clk);
                if (timeout_err) begin tcnt++; tpos = n; end
                if (resp_valid) rvc++;
            end
            check("timeout_pulses", 64'(tcnt), 64'd1);
            check("timeout_wait_cycle", 64'(tpos - 1), 64'd16);
            check("timeout_no_resp", 64'(rvc), 64'd0);
        end else if (kind == K_RESET) begin
            repeat (4) @(negedge clk);
            @(posedge clk); #1;
            rst = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check_reset_outputs("midreset");
            @(posedge clk); #1;
            rst = 1'b1;
            model_last = NREQ - 1;
        end else if (kind == K_STALL) begin
            n = 0;
            while (!resp_valid && n < 60) begin
                @(negedge clk);
                n++;
            end
            check("stall_resp_seen", 64'(resp_valid), 64'd1);
            @(posedge clk); #1;
            req_valid = '1;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                check("stall_resp_valid", 64'(resp_valid), 64'd1);
                check("stall_no_grant", 64'(req_ready), 64'd0);
                check("stall_resp_id", 64'(resp_id), 64'(e.id));
                check("stall_resp_data", resp_data, e.data);
            end
            @(posedge clk); #1;
            req_valid = '0;
            rr_force  = 1;
            wait_drained();
        end else begin
            if (fixed) begin
                n = 0; svc = 0;
                while (!resp_valid && n < 60) begin
                    @(negedge clk);
                    n++;
                    if (sort_valid_in) svc++;
                end
                check("accept_to_resp_valid", 64'(n - 1), 64'd10);
                check("issue_pulses", 64'(svc), 64'd1);
                check("first_resp_id", 64'(resp_id), 64'd0);
                check("first_resp_data", resp_data, 64'h0102030405060708);
            end
            wait_drained();
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b1;
        mon_en = 1;

        do_job(4'b0001, K_NORMAL, 1, 64'h0807060504030201);
        check("done_after_first", 64'(done_cnt), 64'd1);

        for (int j = 0; j < 4; j++) do_job(4'b1111, K_NORMAL, 0, 64'd0);
        check("done_after_five", 64'(done_cnt), 64'd5);

        do_job(4'b0100, K_NORMAL, 0, 64'd0);
        do_job(4'b0101, K_NORMAL, 0, 64'd0);
        do_job(4'b0101, K_NORMAL, 0, 64'd0);

        do_job(4'b1000, K_MUTE, 0, 64'd0);
        do_job(4'b0010, K_NORMAL, 0, 64'd0);

        rr_force = 0;
        do_job(4'b0110, K_STALL, 0, 64'd0);
        do_job(4'b1001, K_RESET, 0, 64'd0);
        do_job(4'b0011, K_NORMAL, 0, 64'd0);

`ifdef SORT_ORDER_CHECK_EN
        do_job(4'b0001, K_BAD, 0, 64'd0);
`endif

        rr_rand = 1;
        for (int j = 0; j < 40; j++)
            do_job(NREQ'($urandom_range(1, (1 << NREQ) - 1)),
                   ($urandom_range(0, 7) == 0) ? K_MUTE : K_NORMAL, 0, 64'd0);

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1);
    end

endmodule
